// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and widths for the CPU memory arbiter
package cpu_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
  typedef enum logic [1:0] {NONE, IF, LS} owner_t;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - saturating cycle counter that flags a hung transaction
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // count holds k-1 in the k-th waiting cycle, so expiry lands TIMEOUT cycles after clear
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX  = '1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-outstanding memory port between IF and LS
module mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              bus_err,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_d;
  owner_t     owner, owner_d;
  logic       grant_ls, grant_if, accept, resp_real, resp_forced, expired, in_wait;

  assign in_wait = (state == WAIT);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (in_wait),
    .expired (expired)
  );

  // LS wins ties: its instruction has already been fetched
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    grant_ls    = 1'b0;
    grant_if    = 1'b0;
    accept      = 1'b0;
    resp_real   = 1'b0;
    resp_forced = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req) begin
          grant_ls = 1'b1;
          owner_d  = LS;
          state_d  = REQ;
        end else if (if_req) begin
          grant_if = 1'b1;
          owner_d  = IF;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          resp_real = 1'b1;
          owner_d   = NONE;
          state_d   = IDLE;
        end else if (expired) begin
          resp_forced = 1'b1;
          owner_d     = NONE;
          state_d     = IDLE;
        end
      end
      default: begin
        owner_d = NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= NONE;
    end else begin
      state <= state_d;
      owner <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (grant_ls) begin
      mem_wen   <= ls_wen;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
      mem_wmask <= ls_wmask;
    end else if (grant_if) begin
      mem_wen   <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end
  end

  assign mem_req   = (state == REQ);
  assign bus_err   = resp_forced;
  assign if_rvalid = (resp_real || resp_forced) && (owner == IF);
  assign ls_rvalid = (resp_real || resp_forced) && (owner == LS);
  // forced responses carry zero data; real data passes straight through
  assign if_rdata  = (resp_real && (owner == IF)) ? mem_rdata : '0;
  assign ls_rdata  = (resp_real && (owner == LS)) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_rvalid, ls_req, ls_wen, ls_rvalid, bus_err;
  logic        mem_req, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  ls_wmask, mem_wmask;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_wen     (ls_wen),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_wmask   (ls_wmask),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wen = 1'b0;
    ls_addr = '0; ls_wdata = '0; ls_wmask = '0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_if_rvalid", if_rvalid, 1'b0);
    chkb("rst_ls_rvalid", ls_rvalid, 1'b0);
    chkb("rst_bus_err", bus_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    next_cycle(); next_cycle(); rst = 1'b1;

    // single IF read
    next_cycle(); if_req = 1'b1; if_addr = 32'h8000_0000; mem_ready = 1'b1; #2;
    chkb("t1_idle_no_req", mem_req, 1'b0);
    next_cycle(); #2;
    chkb("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    chkb("t1_mem_wen", mem_wen, 1'b0);
    next_cycle(); mem_ready = 1'b0; #2;
    chkb("t1_wait_req_low", mem_req, 1'b0);
    chkb("t1_no_early_rvalid", if_rvalid, 1'b0);
    next_cycle(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; #2;
    chkb("t1_if_rvalid", if_rvalid, 1'b1);
    chk("t1_if_rdata", if_rdata, 32'h13);
    chkb("t1_ls_rvalid", ls_rvalid, 1'b0);
    chkb("t1_bus_err", bus_err, 1'b0);
    next_cycle(); mem_rvalid = 1'b0; if_req = 1'b0; #2;
    chkb("t1_rvalid_pulse", if_rvalid, 1'b0);
    chk("t1_rdata_zero", if_rdata, 32'h0);

    // simultaneous IF and LS store: LS first
    next_cycle();
    if_req = 1'b1; if_addr = 32'h8000_0004;
    ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 32'h8000_1000; ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF;
    mem_ready = 1'b1;
    next_cycle(); ls_addr = 32'h1111_1111; ls_wdata = 32'h0; #2;
    chkb("t2_mem_req", mem_req, 1'b1);
    chkb("t2_mem_wen", mem_wen, 1'b1);
    chk("t2_mem_addr", mem_addr, 32'h8000_1000);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_mem_wmask", {28'h0, mem_wmask}, 32'hF);
    next_cycle(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0; #2;
    chkb("t2_ls_rvalid", ls_rvalid, 1'b1);
    chkb("t2_if_not_owner", if_rvalid, 1'b0);
    chk("t2_addr_held", mem_addr, 32'h8000_1000);
    next_cycle(); mem_rvalid = 1'b0; ls_req = 1'b0; #2;
    chkb("t2_idle_gap", mem_req, 1'b0);

    // IF now in REQ: backpressure for 5 cycles, accept on the 6th
    next_cycle(); if_addr = 32'h0BAD_0BAD; #2;
    chkb("t3_if_req_rise", mem_req, 1'b1);
    chk("t3_if_addr", mem_addr, 32'h8000_0004);
    chkb("t3_if_wen", mem_wen, 1'b0);
    chk("t3_if_wmask", {28'h0, mem_wmask}, 32'h0);
    chk("t3_if_wdata", mem_wdata, 32'h0);
    for (int i = 1; i < 5; i++) begin
      next_cycle(); #2;
      chkb("t3_bp_req", mem_req, 1'b1);
      chk("t3_bp_addr", mem_addr, 32'h8000_0004);
      chkb("t3_bp_no_err", bus_err, 1'b0);
    end
    next_cycle(); mem_ready = 1'b1; #2;
    chkb("t3_accept_req", mem_req, 1'b1);
    next_cycle(); mem_ready = 1'b0; #2;
    chkb("t3_wait_req_low", mem_req, 1'b0);
    chkb("t3_wait_no_rvalid", if_rvalid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
    chkb("t3_if_rvalid", if_rvalid, 1'b1);
    chk("t3_if_rdata", if_rdata, 32'hCAFE_F00D);
    chkb("t3_no_err", bus_err, 1'b0);
    next_cycle(); mem_rvalid = 1'b0; if_req = 1'b0;

    // timeout: no response for 4 cycles after accept
    next_cycle(); ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 32'h0000_0100; mem_ready = 1'b1;
    next_cycle(); #2;
    chkb("t4_mem_req", mem_req, 1'b1);
    next_cycle(); mem_ready = 1'b0; mem_rdata = 32'h5555_5555; #2;
    chkb("t4_a1_rvalid", ls_rvalid, 1'b0);
    next_cycle(); #2;
    chkb("t4_a2_err", bus_err, 1'b0);
    next_cycle(); #2;
    chkb("t4_a3_rvalid", ls_rvalid, 1'b0);
    chkb("t4_a3_err", bus_err, 1'b0);
    next_cycle(); #2;
    chkb("t4_timeout_rvalid", ls_rvalid, 1'b1);
    chkb("t4_timeout_err", bus_err, 1'b1);
    chk("t4_timeout_rdata", ls_rdata, 32'h0);
    chkb("t4_timeout_if", if_rvalid, 1'b0);
    next_cycle(); ls_req = 1'b0; mem_rvalid = 1'b1; #2;
    chkb("t4_stray_rvalid", ls_rvalid, 1'b0);
    chkb("t4_stray_err", bus_err, 1'b0);
    chkb("t4_idle_req", mem_req, 1'b0);

    // response on the same cycle the watchdog expires
    next_cycle(); mem_rvalid = 1'b0; ls_req = 1'b1; ls_addr = 32'h0000_0200; mem_ready = 1'b1;
    next_cycle(); #2;
    chkb("t4b_mem_req", mem_req, 1'b1);
    next_cycle(); mem_ready = 1'b0;
    next_cycle();
    next_cycle(); #2;
    chkb("t4b_a3_rvalid", ls_rvalid, 1'b0);
    next_cycle(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #2;
    chkb("t4b_rvalid", ls_rvalid, 1'b1);
    chk("t4b_rdata", ls_rdata, 32'h1234_5678);
    chkb("t4b_no_err", bus_err, 1'b0);
    next_cycle(); mem_rvalid = 1'b0; ls_req = 1'b0;

    // async reset while in REQ
    next_cycle(); if_req = 1'b1; if_addr = 32'h8000_0040; mem_ready = 1'b0;
    next_cycle(); #2;
    chkb("t5_req_before_rst", mem_req, 1'b1);
    #2; rst = 1'b0; #1;
    chkb("t5_req_drop", mem_req, 1'b0);
    chk("t5_addr_clear", mem_addr, 32'h0);
    next_cycle(); rst = 1'b1; mem_ready = 1'b1;
    next_cycle(); #2;
    chkb("t5_regrant", mem_req, 1'b1);
    chk("t5_regrant_addr", mem_addr, 32'h8000_0040);

    // async reset mid-WAIT while a response is being presented
    next_cycle(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077; #2;
    chkb("t5_wait_rvalid", if_rvalid, 1'b1);
    rst = 1'b0; #1;
    chkb("t5_rvalid_drop", if_rvalid, 1'b0);
    chk("t5_rdata_drop", if_rdata, 32'h0);
    chk("t5_wait_addr_clear", mem_addr, 32'h0);
    next_cycle(); rst = 1'b1; if_req = 1'b0; #2;
    chkb("t5_stray_if", if_rvalid, 1'b0);
    chkb("t5_stray_ls", ls_rvalid, 1'b0);
    chkb("t5_stray_req", mem_req, 1'b0);
    next_cycle(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h8000_0080; mem_ready = 1'b1; #2;
    chkb("t5_new_idle", mem_req, 1'b0);
    next_cycle(); #2;
    chkb("t5_new_req", mem_req, 1'b1);
    chk("t5_new_addr", mem_addr, 32'h8000_0080);
    next_cycle(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_ABCD; #2;
    chkb("t5_new_rvalid", if_rvalid, 1'b1);
    chk("t5_new_rdata", if_rdata, 32'h0000_ABCD);
    next_cycle(); mem_rvalid = 1'b0; if_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one 32-bit single-outstanding memory port between the instruction-fetch requester (IF) and the load/store requester (LS) of the CPU. It sits between the CPU core and the unified SRAM controller, replacing the separate single-cycle iram/dram ports once memory becomes multi-cycle. It latches one request at a time, drives the downstream req/ready handshake and routes the response back to the owner. A watchdog terminates hung transactions.

## Interface
Parameters:
- TIMEOUT, 255: max cycles in WAIT before a forced error response; legal range 1..65535.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request, held until if_rvalid
- if_addr  in  32  IF read address
- if_rvalid  out  1  one-cycle pulse, IF response valid
- if_rdata  out  32  IF read data, valid with if_rvalid
- ls_req  in  1  LS request, held until ls_rvalid
- ls_wen  in  1  1 = store, 0 = load
- ls_addr  in  32  LS address
- ls_wdata  in  32  store data
- ls_wmask  in  4  store byte mask
- ls_rvalid  out  1  one-cycle pulse, LS done (load data or store ack)
- ls_rdata  out  32  load data, valid with ls_rvalid
- bus_err  out  1  one-cycle pulse with the forced rvalid on timeout
- mem_req  out  1  downstream request, held until mem_ready
- mem_ready  in  1  downstream accepts request this cycle
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/32/32/4  latched request fields
- mem_rvalid  in  1  downstream response pulse
- mem_rdata  in  32  downstream read data

## Operation
- States: IDLE, REQ, WAIT. Owner register: NONE, IF, LS.
- IDLE: if ls_req, latch LS fields, owner=LS, go REQ; else if if_req, latch if_addr with wen=0, wmask=0, wdata=0, owner=IF, go REQ. LS has fixed priority over IF, because an LS request belongs to an instruction that has already been fetched.
- REQ: mem_req=1 with the latched fields. On mem_ready go WAIT and clear the watchdog.
- WAIT: on mem_rvalid, pulse the owner's rvalid and pass mem_rdata through combinationally, then go IDLE with owner=NONE. For stores, ls_rdata is don't-care.
- Watchdog: counts cycles in WAIT. When the count equals TIMEOUT with no mem_rvalid, pulse the owner's rvalid with rdata=0, pulse bus_err, go IDLE.
- mem_rvalid outside WAIT is ignored.
- mem_rvalid on the same cycle the counter reaches TIMEOUT: the real response wins and bus_err stays 0.
- Requester deasserts req mid-transaction: the transaction still completes and rvalid still pulses. The requester ignores it.
- Request fields are sampled only at the grant. Input changes during REQ/WAIT have no effect.
- Non-owner rvalid is always 0. rdata outputs are 0 whenever their rvalid is 0.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, owner=NONE, counter=0. mem_req, if_rvalid, ls_rvalid and bus_err all 0. mem_* fields 0. Takes effect immediately, even mid-transaction. mem_req drops without waiting for a clock edge.
- Request seen in IDLE at cycle N: mem_req=1 at N+1.
- mem_ready at N+1: WAIT from N+2. Earliest mem_rvalid is N+2, so the earliest requester rvalid is N+2.
- Back-to-back: after the response cycle the arbiter is IDLE for one cycle. The next mem_req rises 2 cycles after the previous rvalid.
- Timeout: with mem_ready at cycle A and no response, the forced rvalid and bus_err come at cycle A+TIMEOUT.
- mem_req stays high across any number of mem_ready=0 cycles. There is no timeout in REQ.

## Structure
- Package cpu_bus_pkg: arb_state_t enum {IDLE, REQ, WAIT}, owner_t enum {NONE, IF, LS}, constants ADDR_W=32, DATA_W=32, MASK_W=4.
- Sub-module arb_watchdog: clear and enable inputs, expired output. Counter width is $clog2(TIMEOUT+1); saturates and does not wrap.
- The top level holds the FSM, owner and latch registers, and response routing.

## Test plan
- Single IF read: if_req with if_addr=0x8000_0000, mem_ready=1 immediately, mem_rvalid 2 cycles after accept with rdata=0x0000_0013 -> mem_addr=0x8000_0000 and mem_wen=0; one if_rvalid pulse carrying 0x13; ls_rvalid stays 0.
- Simultaneous requests: if_req and ls_req (store, addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF) in the same IDLE cycle -> LS is served first with mem_wen=1 and the latched fields; IF mem_req rises 2 cycles after ls_rvalid.
- Backpressure: mem_ready held 0 for 5 cycles -> mem_req and fields stay stable for all 6 cycles; WAIT is entered only after accept; no timeout fires.
- Timeout with TIMEOUT=4: accept, then no mem_rvalid -> ls_rvalid and bus_err pulse together exactly 4 cycles after accept, rdata=0; state returns to IDLE. With mem_rvalid on the 4th cycle -> bus_err=0 and real data is returned.
- Reset mid-WAIT: assert rst low between clock edges -> mem_req and all outputs go 0 immediately. After release, a stray mem_rvalid produces no rvalid, and a new if_req proceeds normally.
